// File: rtl/topk_pkg.sv
// Shared types for the top-k sort scheduler: requester id and the delay-line entry
// that shadows each group while it is inside the external sorter.
package topk_pkg;

  // Ids are carried at this width internally and trimmed to clog2(NUM_REQ) at the port.
  localparam int MAX_NUM_REQ = 256;
  localparam int REQ_ID_W    = $clog2(MAX_NUM_REQ);

  typedef logic [REQ_ID_W-1:0] req_id_t;

  typedef struct packed {
    logic    valid;
    req_id_t id;
  } sched_entry_t;

endpackage

// File: rtl/topk_sched_fifo.sv
// Register-based first-word-fall-through result buffer; a push while full is
// accepted only when a pop happens in the same cycle.
module topk_sched_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty_o = (count == '0);
  assign full_o  = (count == CW'(DEPTH));
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);
  assign data_o  = mem[rd_ptr];

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr] <= data_i;
  end

endmodule

// File: rtl/topk_sort_sched.sv
// Round-robin scheduler feeding a fixed-latency external sorter with credit-based result
// buffering. Optional performance counters: define TOPK_SORT_SCHED_PERF_EN.
module topk_sort_sched
  import topk_pkg::*;
#(
  parameter int DATAWIDTH    = 8,
  parameter int DATALENGTH   = 4,
  parameter int NUM_REQ      = 4,
  parameter int SORT_LATENCY = 3,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                                             clk_i,
  input  logic                                             rstn_i,
  input  logic [NUM_REQ-1:0]                               req_valid_i,
  output logic [NUM_REQ-1:0]                               req_ready_o,
  input  logic [NUM_REQ-1:0][DATALENGTH-1:0][DATAWIDTH-1:0] req_data_i,
  output logic                                             sort_valid_o,
  output logic [DATALENGTH-1:0][DATAWIDTH-1:0]             sort_x_o,
  input  logic [DATALENGTH-1:0][DATAWIDTH-1:0]             sort_y_i,
  output logic                                             res_valid_o,
  input  logic                                             res_ready_i,
  output logic [$clog2(NUM_REQ)-1:0]                       res_id_o,
  output logic [DATALENGTH-1:0][DATAWIDTH-1:0]             res_data_o,
  output logic [31:0]                                      perf_issued_o,
  output logic [31:0]                                      perf_stall_o
);

  localparam int IDW = $clog2(NUM_REQ);
  localparam int GW  = DATALENGTH * DATAWIDTH;
  localparam int CRW = $clog2(FIFO_DEPTH + 1);

  logic [IDW-1:0]    rr_ptr;
  logic [IDW-1:0]    grant_idx;
  logic [IDW-1:0]    idx_v;
  logic              grant_found;
  logic [CRW-1:0]    credit;
  logic              credit_full;
  logic              issue_ok;
  logic              accept;
  logic              pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [IDW+GW-1:0] fifo_wdata;
  logic [IDW+GW-1:0] fifo_rdata;
  sched_entry_t      dl [SORT_LATENCY];
  sched_entry_t      tail;
  logic              unused_ok;

  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    idx_v       = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx_v = IDW'((int'(rr_ptr) + k) % NUM_REQ);
      if (!grant_found && req_valid_i[idx_v]) begin
        grant_found = 1'b1;
        grant_idx   = idx_v;
      end
    end
  end

  // A pop in the same cycle frees a slot, so a full credit pool can still issue.
  assign credit_full  = (credit == CRW'(FIFO_DEPTH));
  assign res_valid_o  = rstn_i & ~fifo_empty;
  assign pop          = res_valid_o & res_ready_i;
  assign issue_ok     = rstn_i & (~credit_full | pop);
  assign req_ready_o  = (issue_ok && grant_found) ? (NUM_REQ'(1) << grant_idx) : '0;
  assign accept       = |(req_valid_i & req_ready_o);
  assign sort_valid_o = accept;
  assign sort_x_o     = accept ? req_data_i[grant_idx] : '0;

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      rr_ptr <= '0;
      credit <= '0;
    end else begin
      if (accept) rr_ptr <= (grant_idx == IDW'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
      unique case ({accept, pop})
        2'b10:   credit <= credit + 1'b1;
        2'b01:   credit <= credit - 1'b1;
        default: credit <= credit;
      endcase
    end
  end

  // Shadow of the sorter pipeline; clearing it on reset drops any late sort_y_i data.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      for (int i = 0; i < SORT_LATENCY; i++) dl[i] <= '0;
    end else begin
      dl[0] <= '{valid: accept, id: req_id_t'(grant_idx)};
      for (int i = 1; i < SORT_LATENCY; i++) dl[i] <= dl[i-1];
    end
  end

  assign tail       = dl[SORT_LATENCY-1];
  assign fifo_wdata = {IDW'(tail.id), sort_y_i};

  topk_sched_fifo #(
    .WIDTH (IDW + GW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rstn_i  (rstn_i),
    .push_i  (tail.valid),
    .data_i  (fifo_wdata),
    .pop_i   (pop),
    .data_o  (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign res_id_o   = fifo_rdata[IDW+GW-1:GW];
  assign res_data_o = fifo_rdata[GW-1:0];

  // Credit accounting keeps pushes away from a full buffer, so full is informational only.
  assign unused_ok = ^{fifo_full, tail.id};

`ifdef TOPK_SORT_SCHED_PERF_EN
  logic [31:0] issued_q;
  logic [31:0] stall_q;

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      issued_q <= '0;
      stall_q  <= '0;
    end else begin
      if (accept) issued_q <= issued_q + 32'd1;
      if ((|req_valid_i) && credit_full) stall_q <= stall_q + 32'd1;
    end
  end

  assign perf_issued_o = issued_q;
  assign perf_stall_o  = stall_q;
`else
  assign perf_issued_o = '0;
  assign perf_stall_o  = '0;
`endif

endmodule

// File: tb/tb_topk_sort_sched.sv
// Directed bench for topk_sort_sched with a 3-cycle descending-sort model on sort_y_i.
module tb_topk_sort_sched;

`ifdef TOPK_SORT_SCHED_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic                 clk = 1'b0;
  logic                 rstn;
  logic [3:0]           req_valid;
  logic [3:0]           req_ready;
  logic [3:0][3:0][7:0] req_data;
  logic                 sort_valid;
  logic [3:0][7:0]      sort_x;
  logic [3:0][7:0]      sort_y;
  logic                 res_valid;
  logic                 res_ready;
  logic [1:0]           res_id;
  logic [3:0][7:0]      res_data;
  logic [31:0]          perf_issued;
  logic [31:0]          perf_stall;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  topk_sort_sched #(
    .DATAWIDTH    (8),
    .DATALENGTH   (4),
    .NUM_REQ      (4),
    .SORT_LATENCY (3),
    .FIFO_DEPTH   (4)
  ) dut (
    .clk_i         (clk),
    .rstn_i        (rstn),
    .req_valid_i   (req_valid),
    .req_ready_o   (req_ready),
    .req_data_i    (req_data),
    .sort_valid_o  (sort_valid),
    .sort_x_o      (sort_x),
    .sort_y_i      (sort_y),
    .res_valid_o   (res_valid),
    .res_ready_i   (res_ready),
    .res_id_o      (res_id),
    .res_data_o    (res_data),
    .perf_issued_o (perf_issued),
    .perf_stall_o  (perf_stall)
  );

  // External sorter model: fixed 3-cycle latency, not reset, element 0 = largest.
  logic [3:0][7:0] spipe [3] = '{default: '0};

  function automatic logic [3:0][7:0] sort_desc(input logic [3:0][7:0] x);
    logic [3:0][7:0] y;
    logic [7:0]      t;
    y = x;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3 - i; j++)
        if (y[j] < y[j+1]) begin
          t = y[j]; y[j] = y[j+1]; y[j+1] = t;
        end
    return y;
  endfunction

  always @(posedge clk) begin
    spipe[0] <= sort_x;
    spipe[1] <= spipe[0];
    spipe[2] <= spipe[1];
  end
  assign sort_y = sort_desc(spipe[2]);

  // Groups per requester (element 0 in the low byte) and their hand-sorted results.
  localparam logic [31:0] IN0 = 32'h02040103;  // {3,1,4,2}
  localparam logic [31:0] IN1 = 32'h05080709;  // {9,7,8,5}
  localparam logic [31:0] IN2 = 32'h1010FF00;  // {0,255,16,16}
  localparam logic [31:0] IN3 = 32'h281E140A;  // {10,20,30,40}
  logic [31:0] in_by_id  [4] = '{IN0, IN1, IN2, IN3};
  logic [31:0] srt_by_id [4] = '{32'h01020304, 32'h05070809, 32'h001010FF, 32'h0A141E28};

  typedef struct {
    logic [3:0] valid;
    logic [3:0] exp_ready;
    logic [1:0] exp_grant;
    logic       exp_rv;
    logic [1:0] exp_id;
  } vec_t;

  vec_t tbl [15];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic cyc(input logic [3:0] v, input logic rr);
    @(negedge clk);
    req_valid = v;
    res_ready = rr;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn = 1'b0; req_valid = 4'h0; res_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
  endtask

  initial begin
    rstn      = 1'b0;
    req_valid = 4'hF;
    res_ready = 1'b1;
    for (int i = 0; i < 4; i++) req_data[i] = in_by_id[i];

    tbl[0]  = '{4'hF, 4'b0001, 2'd0, 1'b0, 2'd0};
    tbl[1]  = '{4'hF, 4'b0010, 2'd1, 1'b0, 2'd0};
    tbl[2]  = '{4'hF, 4'b0100, 2'd2, 1'b0, 2'd0};
    tbl[3]  = '{4'hF, 4'b1000, 2'd3, 1'b0, 2'd0};
    tbl[4]  = '{4'hF, 4'b0001, 2'd0, 1'b1, 2'd0};
    tbl[5]  = '{4'hA, 4'b0010, 2'd1, 1'b1, 2'd1};
    tbl[6]  = '{4'h9, 4'b1000, 2'd3, 1'b1, 2'd2};
    tbl[7]  = '{4'h6, 4'b0010, 2'd1, 1'b1, 2'd3};
    tbl[8]  = '{4'h0, 4'b0000, 2'd0, 1'b1, 2'd0};
    tbl[9]  = '{4'h1, 4'b0001, 2'd0, 1'b1, 2'd1};
    tbl[10] = '{4'hC, 4'b0100, 2'd2, 1'b1, 2'd3};
    tbl[11] = '{4'h0, 4'b0000, 2'd0, 1'b1, 2'd1};
    tbl[12] = '{4'h0, 4'b0000, 2'd0, 1'b0, 2'd0};
    tbl[13] = '{4'h0, 4'b0000, 2'd0, 1'b1, 2'd0};
    tbl[14] = '{4'h0, 4'b0000, 2'd0, 1'b1, 2'd2};

    // Reset state with all requesters asserting
    #1;
    chk("rst_ready", req_ready, 4'h0);
    chk("rst_sort_valid", sort_valid, 1'b0);
    chk("rst_res_valid", res_valid, 1'b0);
    @(negedge clk);
    @(negedge clk);
    chk("rst_perf_issued", perf_issued, 32'd0);
    chk("rst_perf_stall", perf_stall, 32'd0);
    rstn = 1'b1; req_valid = 4'h0;

    // Single group from requester 0
    cyc(4'b0001, 1'b1);
    chk("single_ready", req_ready, 4'b0001);
    chk("single_sort_valid", sort_valid, 1'b1);
    chk("single_sort_x", sort_x, IN0);
    for (int c = 1; c <= 3; c++) begin
      cyc(4'b0000, 1'b1);
      chk("single_res_early", res_valid, 1'b0);
    end
    cyc(4'b0000, 1'b1);
    chk("single_res_valid", res_valid, 1'b1);
    chk("single_res_id", res_id, 2'd0);
    chk("single_res_data", res_data, 32'h01020304);
    cyc(4'b0000, 1'b1);
    chk("single_res_drained", res_valid, 1'b0);

    // Round-robin table with back-to-back issue and in-order results
    do_reset();
    for (int s = 0; s < 15; s++) begin
      cyc(tbl[s].valid, 1'b1);
      chk($sformatf("rr%0d_ready", s), req_ready, tbl[s].exp_ready);
      chk($sformatf("rr%0d_sort_valid", s), sort_valid, |tbl[s].exp_ready);
      if (|tbl[s].exp_ready)
        chk($sformatf("rr%0d_sort_x", s), sort_x, in_by_id[tbl[s].exp_grant]);
      chk($sformatf("rr%0d_res_valid", s), res_valid, tbl[s].exp_rv);
      if (tbl[s].exp_rv) begin
        chk($sformatf("rr%0d_res_id", s), res_id, tbl[s].exp_id);
        chk($sformatf("rr%0d_res_data", s), res_data, srt_by_id[tbl[s].exp_id]);
      end
    end

    // Back-pressure: credit fills at 4, one-cycle release allows pop + accept
    do_reset();
    for (int c = 0; c < 4; c++) begin
      cyc(4'hF, 1'b0);
      chk($sformatf("bp%0d_ready", c), req_ready, 4'b0001 << c);
    end
    for (int c = 4; c < 8; c++) begin
      cyc(4'hF, 1'b0);
      chk($sformatf("bp%0d_blocked", c), req_ready, 4'h0);
      chk($sformatf("bp%0d_res_valid", c), res_valid, 1'b1);
    end
    cyc(4'hF, 1'b1);
    chk("bp_release_res_id", res_id, 2'd0);
    chk("bp_release_ready", req_ready, 4'b0001);
    chk("bp_release_sort_valid", sort_valid, 1'b1);
    cyc(4'hF, 1'b0);
    chk("bp_reblocked", req_ready, 4'h0);
    chk("bp_perf_issued", perf_issued, PERF ? 32'd5 : 32'd0);
    chk("bp_perf_stall", perf_stall, PERF ? 32'd5 : 32'd0);
    begin
      logic [1:0] drain_ids [4] = '{2'd1, 2'd2, 2'd3, 2'd0};
      for (int c = 0; c < 4; c++) begin
        cyc(4'h0, 1'b1);
        chk($sformatf("drain%0d_valid", c), res_valid, 1'b1);
        chk($sformatf("drain%0d_id", c), res_id, drain_ids[c]);
        chk($sformatf("drain%0d_data", c), res_data, srt_by_id[drain_ids[c]]);
      end
    end
    cyc(4'h0, 1'b1);
    chk("drain_empty", res_valid, 1'b0);

    // Reset with three groups inside the sorter
    do_reset();
    for (int c = 0; c < 3; c++) cyc(4'hF, 1'b1);
    @(negedge clk);
    rstn = 1'b0; req_valid = 4'hF;
    #1;
    chk("mid_rst_ready", req_ready, 4'h0);
    chk("mid_rst_sort_valid", sort_valid, 1'b0);
    chk("mid_rst_res_valid", res_valid, 1'b0);
    @(negedge clk);
    rstn = 1'b1; req_valid = 4'h0;
    #1;
    chk("mid_rst_perf_issued", perf_issued, 32'd0);
    chk("mid_rst_perf_stall", perf_stall, 32'd0);
    for (int c = 0; c < 6; c++) begin
      cyc(4'h0, 1'b1);
      chk($sformatf("mid_rst_late%0d", c), res_valid, 1'b0);
    end
    cyc(4'hF, 1'b1);
    chk("mid_rst_rr_ptr", req_ready, 4'b0001);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/topk_sort_sched.md
TOPK_SORT_SCHED -- requirements
Module: topk_sort_sched

Interface
REQ-001 SHALL have parameter DATAWIDTH, default 8, element width.
REQ-002 SHALL have parameter DATALENGTH, default 4, elements per sort group.
REQ-003 SHALL have parameter NUM_REQ, default 4, number of requesters (>=2).
REQ-004 SHALL have parameter SORT_LATENCY, default 3, cycles from sort_valid_o to the matching result on sort_y_i.
REQ-005 SHALL have parameter FIFO_DEPTH, default 4, result buffer entries (>=1).
REQ-006 SHALL have port clk_i, input, 1, sole clock; one clock only.
REQ-007 SHALL have port rstn_i, input, 1, reset; synchronous and active-low.
REQ-008 SHALL have port req_valid_i, input, NUM_REQ, per-requester group valid.
REQ-009 SHALL have port req_ready_o, output, NUM_REQ, per-requester accept.
REQ-010 SHALL have port req_data_i, input, NUM_REQ x DATALENGTH x DATAWIDTH, unsorted groups.
REQ-011 SHALL have port sort_valid_o, input-side issue strobe to sorter, output, 1.
REQ-012 SHALL have port sort_x_o, output, DATALENGTH x DATAWIDTH, group driven to sorter.
REQ-013 SHALL have port sort_y_i, input, DATALENGTH x DATAWIDTH, sorter result.
REQ-014 SHALL have ports res_valid_o (out, 1), res_ready_i (in, 1), res_id_o (out, clog2(NUM_REQ)), res_data_o (out, DATALENGTH x DATAWIDTH): result stream.
REQ-015 SHALL have ports perf_issued_o and perf_stall_o, output, 32 each, performance counters.

Function
REQ-016 Credit count = groups in flight + FIFO entries; issue allowed only when credit < FIFO_DEPTH.
REQ-017 Round-robin arbitration: among asserted req_valid_i, grant first index at or after rr pointer, wrapping NUM_REQ-1 -> 0.
REQ-018 req_ready_o SHALL be one-hot at granted index when issue allowed, else all zero; accept = valid & ready same cycle.
REQ-019 On accept: sort_valid_o=1, sort_x_o=req_data_i[grant] combinationally same cycle; rr pointer := grant+1 (mod NUM_REQ) next cycle.
REQ-020 No accept: sort_valid_o=0, sort_x_o=0, pointer holds.
REQ-021 Delay line of SORT_LATENCY stages carries {valid, id}; at its tail valid, sort_y_i and id SHALL be written into result FIFO that cycle.
REQ-022 Result FIFO first-word-fall-through from registers: res_valid_o=1 iff non-empty; pop on res_valid_o & res_ready_i.
REQ-023 Minimum latency accept -> res_valid_o SHALL be SORT_LATENCY+1 cycles; results emerge in issue order.
REQ-024 Credit: +1 on accept, -1 on pop, unchanged on both same cycle.
REQ-025 FIFO full with simultaneous push and pop SHALL be legal; credit rule guarantees push never hits full without pop.
REQ-026 With FIFO_DEPTH >= SORT_LATENCY+1 and res_ready_i held 1, one accept per cycle sustained.
REQ-027 Sorter is not stallable; module never gates sorter pipeline.

Reset
REQ-028 rstn_i low at clock edge: delay line valids, FIFO pointers, credit, rr pointer (0), counters cleared.
REQ-029 Outputs during/after reset: req_ready_o=0 while rstn_i low, sort_valid_o=0, res_valid_o=0, counters 0.
REQ-030 Reset mid-operation discards in-flight groups; late sort_y_i data SHALL be ignored.

Configuration
REQ-031 Macro TOPK_SORT_SCHED_PERF_EN defined: perf_issued_o counts accepts; perf_stall_o counts cycles with any req_valid_i high and credit == FIFO_DEPTH; both wrap at 2^32.
REQ-032 Macro undefined: counters not implemented, both ports tied 0.

Structure
REQ-033 topk_pkg SHALL hold a request-id typedef sized from NUM_REQ and a sched delay-line entry struct {valid, id}.
REQ-034 Result buffer SHALL be sub-module topk_sched_fifo (parameterised width/depth, push/pop/full/empty).

Verification
REQ-035 Single requester 0, group {3,1,4,2}, res_ready_i=1 -> res_valid_o at cycle 4 after accept, res_id_o=0, data equals sort_y_i model.
REQ-036 All four req_valid_i held high, res_ready_i=1 -> grants 0,1,2,3,0 on consecutive cycles, res_id_o same order.
REQ-037 res_ready_i=0, continuous requests -> exactly 4 accepts, then req_ready_o=0; perf_stall_o increments each blocked cycle (macro on).
REQ-038 Blocked state, release res_ready_i for one cycle -> one pop, one new accept same cycle, credit stays 4.
REQ-039 Assert rstn_i low with 3 groups in flight -> no res_valid_o afterwards, rr pointer 0, perf counters 0.
